// File: rtl/tug_referee.sv
// Round referee for tug-of-war: scores pushes off either end, pulses roundReset, stops the game at MAX_SCORE.
// Score and roundReset update one edge after a point; hex is combinational; pulse inputs, no backpressure.
module tug_referee #(
  parameter int MAX_SCORE = 7
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       edgeLeft,
  input  logic       edgeRight,
  output logic       roundReset,
  output logic [2:0] leftScore,
  output logic [2:0] rightScore,
  output logic [1:0] winner,
  output logic [6:0] hexLeft,
  output logic [6:0] hexRight
);

  localparam logic [2:0] MAX = 3'(MAX_SCORE);

  typedef enum logic [1:0] {PLAY, CLEAR, OVER} state_t;

  state_t state, next_state;
  logic   left_pt, right_pt;

  function automatic logic [6:0] seg7(input logic [2:0] v);
    case (v)
      3'd0:    seg7 = 7'b1000000;
      3'd1:    seg7 = 7'b1111001;
      3'd2:    seg7 = 7'b0100100;
      3'd3:    seg7 = 7'b0110000;
      3'd4:    seg7 = 7'b0011001;
      3'd5:    seg7 = 7'b0010010;
      3'd6:    seg7 = 7'b0000010;
      default: seg7 = 7'b1111000;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (reset) begin
      state      <= PLAY;
      leftScore  <= 3'd0;
      rightScore <= 3'd0;
    end else begin
      state <= next_state;
      // A score below MAX is guaranteed in PLAY, since reaching MAX leads to OVER.
      if (left_pt)  leftScore  <= leftScore + 3'd1;
      if (right_pt) rightScore <= rightScore + 3'd1;
    end
  end

  always_comb begin
    left_pt    = 1'b0;
    right_pt   = 1'b0;
    next_state = state;
    roundReset = 1'b0;
    winner     = 2'b00;
    case (state)
      PLAY: begin
        // A simultaneous press holds the cells, so it never scores.
        left_pt  = edgeLeft & L & ~R;
        right_pt = edgeRight & R & ~L;
        if (left_pt | right_pt) next_state = CLEAR;
      end
      CLEAR: begin
        roundReset = 1'b1;
        if (leftScore == MAX || rightScore == MAX) next_state = OVER;
        else                                       next_state = PLAY;
      end
      OVER: begin
        winner = (leftScore == MAX) ? 2'b10 : 2'b01;
      end
      default: next_state = PLAY;
    endcase
  end

  assign hexLeft  = seg7(leftScore);
  assign hexRight = seg7(rightScore);

endmodule

// File: tb/tb_tug_referee.sv
// Bench for tug_referee: directed per-cycle vectors queue their expected outputs; a negedge monitor pops and compares.
module tb_tug_referee;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       L = 1'b0, R = 1'b0, edgeLeft = 1'b0, edgeRight = 1'b0;
  logic       roundReset;
  logic [2:0] leftScore, rightScore;
  logic [1:0] winner;
  logic [6:0] hexLeft, hexRight;

  tug_referee #(.MAX_SCORE(7)) dut (
    .Clock(Clock), .reset(reset), .L(L), .R(R),
    .edgeLeft(edgeLeft), .edgeRight(edgeRight),
    .roundReset(roundReset), .leftScore(leftScore), .rightScore(rightScore),
    .winner(winner), .hexLeft(hexLeft), .hexRight(hexRight)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc++;

  typedef struct {
    int         cyc;
    string      name;
    logic       rr;
    logic [2:0] ls;
    logic [2:0] rs;
    logic [1:0] w;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total  = 0;
  int   passed = 0;

  logic [6:0] seg_tab [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, expv);
    else passed++;
  endtask

  // Compare every queued expectation that belongs to the edge just taken.
  always @(negedge Clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.cyc < cyc) begin
        total++;
        $display("FAIL %s: expectation for cyc %0d never compared (now %0d)", e.name, e.cyc, cyc);
      end else begin
        chk({e.name, "_status"}, {23'd0, roundReset, leftScore, rightScore, winner},
            {23'd0, e.rr, e.ls, e.rs, e.w});
        chk({e.name, "_hex"}, {18'd0, hexLeft, hexRight}, {18'd0, seg_tab[e.ls], seg_tab[e.rs]});
      end
    end
  end

  // Apply one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic l, input logic r, input logic el, input logic er, input logic rst,
                      input string nm, input logic rr, input logic [2:0] ls, input logic [2:0] rs,
                      input logic [1:0] w);
    L = l; R = r; edgeLeft = el; edgeRight = er; reset = rst;
    q.push_back('{cyc + 1, nm, rr, ls, rs, w});
    @(posedge Clock);
    #1;
  endtask

  initial begin
    @(posedge Clock);
    #1;
    step(0, 0, 0, 0, 1, "reset", 0, 0, 0, 2'b00);
    step(0, 0, 0, 0, 0, "idle", 0, 0, 0, 2'b00);

    // Single left point, then return to PLAY.
    step(1, 0, 1, 0, 0, "lpoint", 1, 1, 0, 2'b00);
    step(0, 0, 1, 0, 0, "lclear_done", 0, 1, 0, 2'b00);
    step(0, 0, 1, 0, 0, "lplay", 0, 1, 0, 2'b00);

    // Simultaneous press never scores.
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, "both_press", 0, 1, 0, 2'b00);

    // Wrong-end presses.
    step(1, 0, 0, 1, 0, "wrong_end_l", 0, 1, 0, 2'b00);
    step(0, 1, 1, 0, 0, "wrong_end_r", 0, 1, 0, 2'b00);

    // Right point, and a press during CLEAR is ignored.
    step(0, 1, 0, 1, 0, "rpoint1", 1, 1, 1, 2'b00);
    step(0, 1, 0, 1, 0, "press_in_clear", 0, 1, 1, 2'b00);

    // Right scores up to 7.
    for (int k = 2; k <= 7; k++) begin
      step(0, 1, 0, 1, 0, "rpoint", 1, 1, 3'(k), 2'b00);
      if (k < 7) step(0, 0, 0, 0, 0, "rgap", 0, 1, 3'(k), 2'b00);
    end
    step(0, 0, 0, 0, 0, "right_wins", 0, 1, 7, 2'b01);

    // OVER ignores presses at either end.
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) step(1, 0, 1, 0, 0, "over_hold_l", 0, 1, 7, 2'b01);
      else            step(0, 1, 0, 1, 0, "over_hold_r", 0, 1, 7, 2'b01);
    end

    // Reset while in OVER.
    step(1, 0, 1, 0, 1, "reset_in_over", 0, 0, 0, 2'b00);

    // Continuous left press: one point every two cycles until OVER.
    for (int i = 1; i <= 16; i++) begin
      if (i <= 13 && (i % 2) == 1) step(1, 0, 1, 0, 0, "hold_point", 1, 3'((i + 1) / 2), 0, 2'b00);
      else if (i < 14)             step(1, 0, 1, 0, 0, "hold_clear", 0, 3'(i / 2), 0, 2'b00);
      else                         step(1, 0, 1, 0, 0, "left_wins", 0, 7, 0, 2'b10);
    end

    // Reset while in CLEAR, then scoring resumes.
    step(0, 0, 0, 0, 1, "reset2", 0, 0, 0, 2'b00);
    step(1, 0, 1, 0, 0, "pre_clear_point", 1, 1, 0, 2'b00);
    step(1, 0, 1, 0, 1, "reset_in_clear", 0, 0, 0, 2'b00);
    step(1, 0, 1, 0, 0, "resume_lpoint", 1, 1, 0, 2'b00);
    step(0, 0, 0, 0, 0, "resume_idle", 0, 1, 0, 2'b00);
    step(0, 1, 0, 1, 0, "resume_rpoint", 1, 1, 1, 2'b00);
    step(0, 0, 0, 0, 0, "resume_end", 0, 1, 1, 2'b00);

    step(0, 0, 0, 0, 0, "final_idle", 0, 1, 1, 2'b00);
    @(posedge Clock);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tug_referee.md
# tug_referee

Round referee for the tug-of-war playfield. It watches the two end cells of the light chain together with the conditioned player press pulses, and declares a point when the lit cell is pushed off either end. It keeps per-player scores, emits a one-cycle round-clear pulse that re-centres the playfield, and stops the game when a player reaches the target score. It drives two active-low 7-segment digits for the scores.

## Interface
Parameters:
- MAX_SCORE, default 7: score that ends the game; legal range 1..7.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears the whole block.
- L  in  1  left-player press pulse, one cycle per press (same signal fed to the light cells).
- R  in  1  right-player press pulse, one cycle per press.
- edgeLeft  in  1  lightOn of the leftmost cell.
- edgeRight  in  1  lightOn of the rightmost cell.
- roundReset  out  1  one-cycle pulse; ORed into the light chain's reset by the top level.
- leftScore  out  3  left player's score, 0..MAX_SCORE.
- rightScore  out  3  right player's score, 0..MAX_SCORE.
- winner  out  2  game result: 2'b00 no winner, 2'b10 left wins, 2'b01 right wins.
- hexLeft  out  7  active-low 7-segment display of leftScore.
- hexRight  out  7  active-low 7-segment display of rightScore.

## Operation
- The state machine has three states: PLAY, CLEAR, OVER. Reset puts it in PLAY.
- Left point: in PLAY, a cycle with edgeLeft & L & ~R.
- Right point: in PLAY, a cycle with edgeRight & R & ~L.
- L & R together is never a point; this matches the cells, which hold their state on a simultaneous press.
- The two point conditions are mutually exclusive, so no priority rule is needed.
- PLAY -> CLEAR on a point. On the same edge the scorer's count increments by 1. Otherwise PLAY holds.
- CLEAR -> OVER if either score equals MAX_SCORE. Otherwise CLEAR -> PLAY.
- OVER holds until reset.
- roundReset = (state == CLEAR). It is a Moore output and is never high in PLAY or OVER.
- roundReset is asserted on every point, including the final one, so the playfield re-centres before OVER.
- L, R, edgeLeft and edgeRight are ignored in CLEAR and OVER.
- Scores never exceed MAX_SCORE. No increment can occur in CLEAR or OVER.
- winner is 2'b00 except in OVER. In OVER it is 2'b10 if leftScore == MAX_SCORE, else 2'b01.
- Segment encoding is combinational from the score, bit order {g,f,e,d,c,b,a}, active low:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000

## Timing
- Reset values: state PLAY, roundReset 0, leftScore 0, rightScore 0, winner 00, hexLeft = hexRight = 1000000.
- Reset has priority over every other condition, including reset asserted in CLEAR or OVER.
- A point sampled at edge N gives, after edge N:
  - the score is updated;
  - roundReset is high during cycle N..N+1.
- The light cells re-centre at edge N+1.
- At edge N+1 the block returns to PLAY, or enters OVER. In the OVER case winner is valid from cycle N+1 onward.
- A press in the cycle where roundReset is high cannot score, because the state is CLEAR.
- The first scoreable press after a point is therefore sampled at edge N+2 at the earliest.
- Hex outputs follow their scores in the same cycle, with zero added latency.

## Test plan
- Reset, then drive edgeLeft=1 with L pulsed for 1 cycle:
  - leftScore 0->1 one edge later;
  - roundReset high for exactly 1 cycle;
  - hexLeft = 1111001;
  - state returns to PLAY.
- edgeLeft=1 with L=R=1 for 5 cycles: no score change, roundReset stays 0.
- edgeRight=1 with L pulsed, then edgeLeft=1 with R pulsed (wrong-end presses): no score change.
- Right scores 7 times (MAX_SCORE=7):
  - rightScore = 7;
  - roundReset pulses on the seventh point;
  - winner = 01 from the following cycle and held;
  - further presses at either end are ignored for 20 cycles.
- Hold edgeLeft=1 and L=1 continuously: exactly 1 point per 2 cycles (PLAY, CLEAR alternating), with roundReset toggling each cycle, until OVER.
- Assert reset during CLEAR and again during OVER: all outputs return to their reset values on the next edge, and scoring resumes normally.
